// File: rtl/dallanma_cozucu.sv
// dallanma_cozucu: branch resolution unit.
// Keeps an in-order queue of fetch-time predictions. It checks the oldest one
// against the execute-stage outcome, then drives predictor training and
// pipeline flush/redirect.
// Optional macro PERF_SAYAC_EN adds saturating resolve/mispredict counters.
module dallanma_cozucu #(
    parameter int unsigned DERINLIK        = 4,
    parameter int unsigned ADRES_GENISLIGI = 32
) (
    input  logic                       i_saat,
    input  logic                       i_reset_n,
    input  logic                       i_ongoru_gecerli,
    input  logic [ADRES_GENISLIGI-1:0] i_ongoru_adresi,
    input  logic                       i_ongoru_atladi,
    input  logic [ADRES_GENISLIGI-1:0] i_ongoru_hedef,
    output logic                       o_dolu,
    output logic                       o_bos,
    input  logic                       i_coz_gecerli,
    input  logic [31:0]                i_coz_buyruk,
    input  logic [ADRES_GENISLIGI-1:0] i_coz_adresi,
    input  logic                       i_coz_atladi,
    input  logic [ADRES_GENISLIGI-1:0] i_coz_hedef,
    output logic                       o_guncelle_gecerli,
    output logic [31:0]                o_eski_buyruk,
    output logic [ADRES_GENISLIGI-1:0] o_eski_buyruk_adresi,
    output logic                       o_buyruk_atladi,
    output logic [ADRES_GENISLIGI-1:0] o_atlanan_adres,
    output logic                       o_ongoru_yanlis,
    output logic                       o_boru_temizle,
    output logic [ADRES_GENISLIGI-1:0] o_dogru_adres,
`ifdef PERF_SAYAC_EN
    output logic [31:0]                o_cozulen_sayisi,
    output logic [31:0]                o_yanlis_sayisi,
`endif
    output logic                       o_tasma
);

    localparam int unsigned AW = ADRES_GENISLIGI;
    localparam int unsigned BW = 32;
    localparam int unsigned PW = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] pc_q  [DERINLIK];
    logic [AW-1:0] pc_d  [DERINLIK];
    logic [AW-1:0] tgt_q [DERINLIK];
    logic [AW-1:0] tgt_d [DERINLIK];
    logic          tk_q  [DERINLIK];
    logic          tk_d  [DERINLIK];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          tasma_q, tasma_d;

    logic          upd_q, upd_d, yanlis_q, yanlis_d;
    logic [BW-1:0] buyruk_q, buyruk_d;
    logic [AW-1:0] eski_adr_q, eski_adr_d, hedef_q, hedef_d, dogru_q, dogru_d;
    logic          atladi_q, atladi_d;

    logic          dolu_c, bos_c, yanlis_c, push_ok_c, pop_ok_c;
    logic [AW-1:0] bas_pc_c, bas_tgt_c;
    logic          bas_tk_c;

    // Occupancy flags straight from the count
    assign dolu_c = (count_q == CW'(DERINLIK));
    assign bos_c  = (count_q == '0);
    assign o_dolu = dolu_c;
    assign o_bos  = bos_c;

    // Head entry; empty queue reads as not-taken/target 0 with no PC desync
    always_comb begin
        bas_pc_c  = i_coz_adresi;
        bas_tk_c  = 1'b0;
        bas_tgt_c = '0;
        if (!bos_c) begin
            bas_pc_c  = pc_q[rd_ptr_q];
            bas_tk_c  = tk_q[rd_ptr_q];
            bas_tgt_c = tgt_q[rd_ptr_q];
        end
    end

    // Mispredict detection and push/pop qualification
    always_comb begin
        yanlis_c  = i_coz_gecerli &
                    ((bas_tk_c != i_coz_atladi) ||
                     (bas_tk_c && i_coz_atladi && (bas_tgt_c != i_coz_hedef)) ||
                     (bas_pc_c != i_coz_adresi));
        pop_ok_c  = i_coz_gecerli & ~bos_c;
        push_ok_c = i_ongoru_gecerli & ~yanlis_c & (~dolu_c | i_coz_gecerli);
    end

    // Next-state for queue storage, pointers, count and sticky error
    always_comb begin
        pc_d     = pc_q;
        tk_d     = tk_q;
        tgt_d    = tgt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        tasma_d  = tasma_q;

        if ((i_ongoru_gecerli && dolu_c && !i_coz_gecerli) || (i_coz_gecerli && bos_c)) begin
            tasma_d = 1'b1;
        end

        if (yanlis_c) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok_c) begin
                pc_d[wr_ptr_q]  = i_ongoru_adresi;
                tk_d[wr_ptr_q]  = i_ongoru_atladi;
                tgt_d[wr_ptr_q] = i_ongoru_hedef;
                wr_ptr_d        = PW'(wr_ptr_q + PW'(1));
            end
            if (pop_ok_c) begin
                rd_ptr_d = PW'(rd_ptr_q + PW'(1));
            end
            count_d = CW'(count_q + CW'(push_ok_c) - CW'(pop_ok_c));
        end
    end

    // Next-state for training/redirect outputs; strobes pulse, data holds
    always_comb begin
        upd_d      = i_coz_gecerli;
        yanlis_d   = yanlis_c;
        buyruk_d   = buyruk_q;
        eski_adr_d = eski_adr_q;
        atladi_d   = atladi_q;
        hedef_d    = hedef_q;
        dogru_d    = dogru_q;
        if (i_coz_gecerli) begin
            buyruk_d   = i_coz_buyruk;
            eski_adr_d = i_coz_adresi;
            atladi_d   = i_coz_atladi;
            hedef_d    = i_coz_hedef;
            dogru_d    = i_coz_atladi ? i_coz_hedef : AW'(i_coz_adresi + AW'(4));
        end
    end

    // State registers
    always_ff @(posedge i_saat or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DERINLIK; i++) begin
                pc_q[i]  <= '0;
                tk_q[i]  <= 1'b0;
                tgt_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tasma_q    <= 1'b0;
            upd_q      <= 1'b0;
            yanlis_q   <= 1'b0;
            buyruk_q   <= '0;
            eski_adr_q <= '0;
            atladi_q   <= 1'b0;
            hedef_q    <= '0;
            dogru_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            tk_q       <= tk_d;
            tgt_q      <= tgt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tasma_q    <= tasma_d;
            upd_q      <= upd_d;
            yanlis_q   <= yanlis_d;
            buyruk_q   <= buyruk_d;
            eski_adr_q <= eski_adr_d;
            atladi_q   <= atladi_d;
            hedef_q    <= hedef_d;
            dogru_q    <= dogru_d;
        end
    end

    assign o_guncelle_gecerli   = upd_q;
    assign o_eski_buyruk        = buyruk_q;
    assign o_eski_buyruk_adresi = eski_adr_q;
    assign o_buyruk_atladi      = atladi_q;
    assign o_atlanan_adres      = hedef_q;
    assign o_ongoru_yanlis      = yanlis_q;
    assign o_boru_temizle       = yanlis_q;
    assign o_dogru_adres        = dogru_q;
    assign o_tasma              = tasma_q;

`ifdef PERF_SAYAC_EN
    logic [31:0] cozulen_q, cozulen_d, yanlis_say_q, yanlis_say_d;

    // Saturating resolve and mispredict counters
    always_comb begin
        cozulen_d    = cozulen_q;
        yanlis_say_d = yanlis_say_q;
        if (i_coz_gecerli && (cozulen_q != 32'hFFFF_FFFF)) begin
            cozulen_d = cozulen_q + 32'd1;
        end
        if (yanlis_c && (yanlis_say_q != 32'hFFFF_FFFF)) begin
            yanlis_say_d = yanlis_say_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge i_saat or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cozulen_q    <= '0;
            yanlis_say_q <= '0;
        end else begin
            cozulen_q    <= cozulen_d;
            yanlis_say_q <= yanlis_say_d;
        end
    end

    assign o_cozulen_sayisi = cozulen_q;
    assign o_yanlis_sayisi  = yanlis_say_q;
`endif

endmodule

// File: tb/tb_dallanma_cozucu.sv
// Testbench for dallanma_cozucu: directed scenarios plus randomized traffic
// checked against a queue-based model of the prediction/resolution rules.
module tb_dallanma_cozucu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pv, pt, cv, ct;
    logic [31:0] pa, ptg, cb, ca, ch;
    logic        o_dolu, o_bos, o_upd, o_atl, o_yan, o_tem, o_tasma;
    logic [31:0] o_buy, o_eadr, o_hdf, o_dogru;

    int ntests = 0;
    int nfail  = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tgt;
    } ent_t;

    ent_t        mq[$];
    logic        e_upd, e_yan, e_atl, e_tasma;
    logic [31:0] e_buy, e_adr, e_hdf, e_dogru;

    always #5 clk = ~clk;

    dallanma_cozucu dut (
        .i_saat               (clk),
        .i_reset_n            (rst_n),
        .i_ongoru_gecerli     (pv),
        .i_ongoru_adresi      (pa),
        .i_ongoru_atladi      (pt),
        .i_ongoru_hedef       (ptg),
        .o_dolu               (o_dolu),
        .o_bos                (o_bos),
        .i_coz_gecerli        (cv),
        .i_coz_buyruk         (cb),
        .i_coz_adresi         (ca),
        .i_coz_atladi         (ct),
        .i_coz_hedef          (ch),
        .o_guncelle_gecerli   (o_upd),
        .o_eski_buyruk        (o_buy),
        .o_eski_buyruk_adresi (o_eadr),
        .o_buyruk_atladi      (o_atl),
        .o_atlanan_adres      (o_hdf),
        .o_ongoru_yanlis      (o_yan),
        .o_boru_temizle       (o_tem),
        .o_dogru_adres        (o_dogru),
        .o_tasma              (o_tasma)
    );

    task automatic model_reset();
        mq.delete();
        e_upd = 0; e_yan = 0; e_atl = 0; e_tasma = 0;
        e_buy = 0; e_adr = 0; e_hdf = 0; e_dogru = 0;
    endtask

    // Drive one cycle of stimulus, advance the model, sample 1 ns after the edge
    task automatic step(input logic spv, input logic [31:0] spa, input logic spt,
                        input logic [31:0] sptg, input logic scv, input logic [31:0] scb,
                        input logic [31:0] sca, input logic sct, input logic [31:0] sch);
        logic m, full;
        ent_t h, e;
        pv = spv; pa = spa; pt = spt; ptg = sptg;
        cv = scv; cb = scb; ca = sca; ct = sct; ch = sch;
        full = (mq.size() == 4);
        m = 1'b0;
        if (scv) begin
            if (mq.size() == 0) m = sct;
            else begin
                h = mq[0];
                m = (h.tk != sct) || (h.tk && sct && h.tgt != sch) || (h.pc != sca);
            end
        end
        if (scv && mq.size() == 0) e_tasma = 1'b1;
        if (spv && full && !scv)   e_tasma = 1'b1;
        if (m) mq.delete();
        else begin
            if (scv && mq.size() > 0) void'(mq.pop_front());
            if (spv && (!full || scv)) begin
                e.pc = spa; e.tk = spt; e.tgt = sptg;
                mq.push_back(e);
            end
        end
        e_upd = scv;
        e_yan = m;
        if (scv) begin
            e_buy = scb; e_adr = sca; e_atl = sct; e_hdf = sch;
            e_dogru = sct ? sch : sca + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input logic [31:0] a, input logic t, input logic [31:0] g);
        step(1, a, t, g, 0, 0, 0, 0, 0);
    endtask

    task automatic resolve(input logic [31:0] a, input logic t, input logic [31:0] g);
        step(0, 0, 0, 0, 1, $urandom, a, t, g);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        pv = 0; pa = 0; pt = 0; ptg = 0; cv = 0; cb = 0; ca = 0; ct = 0; ch = 0;
        repeat (2) @(posedge clk);
        #1;
        ntests++;
        if ({o_bos, o_dolu, o_tasma, o_upd, o_yan, o_tem} !== 6'b100000) begin
            nfail++;
            $display("FAIL reset_flags got=%b exp=100000", {o_bos, o_dolu, o_tasma, o_upd, o_yan, o_tem});
        end
        ntests++;
        if ({o_buy, o_eadr, o_hdf, o_dogru, o_atl} !== '0) begin
            nfail++;
            $display("FAIL reset_data got=%h exp=0", {o_buy, o_eadr, o_hdf, o_dogru, o_atl});
        end
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_correct_taken();
        push(32'h100, 1, 32'h180);
        resolve(32'h100, 1, 32'h180);
        ntests++;
        if ({o_upd, o_yan, o_tem, o_bos, o_dogru} !== {4'b1001, 32'h180}) begin
            nfail++;
            $display("FAIL correct_taken got=%h exp=%h", {o_upd, o_yan, o_tem, o_bos, o_dogru}, {4'b1001, 32'h180});
        end
        idle();
        ntests++;
        if ({o_upd, o_yan, o_dogru} !== {2'b00, 32'h180}) begin
            nfail++;
            $display("FAIL pulse_hold got=%h exp=%h", {o_upd, o_yan, o_dogru}, {2'b00, 32'h180});
        end
    endtask

    task automatic test_direction_mispredict();
        push(32'h200, 0, 32'h0);
        push(32'h204, 1, 32'h300);
        resolve(32'h200, 1, 32'h240);
        ntests++;
        if ({o_upd, o_yan, o_tem, o_bos, o_atl, o_dogru, o_eadr} !== {5'b11111, 32'h240, 32'h200}) begin
            nfail++;
            $display("FAIL dir_mispredict got=%h exp=%h", {o_upd, o_yan, o_tem, o_bos, o_atl, o_dogru, o_eadr},
                     {5'b11111, 32'h240, 32'h200});
        end
    endtask

    task automatic test_target_mispredict();
        push(32'h400, 1, 32'h500);
        resolve(32'h400, 0, 32'h1234);
        ntests++;
        if ({o_yan, o_tem, o_dogru} !== {2'b11, 32'h404}) begin
            nfail++;
            $display("FAIL nt_redirect got=%h exp=%h", {o_yan, o_tem, o_dogru}, {2'b11, 32'h404});
        end
        push(32'h600, 1, 32'h700);
        resolve(32'h600, 1, 32'h710);
        ntests++;
        if ({o_yan, o_dogru, o_hdf} !== {1'b1, 32'h710, 32'h710}) begin
            nfail++;
            $display("FAIL tgt_mispredict got=%h exp=%h", {o_yan, o_dogru, o_hdf}, {1'b1, 32'h710, 32'h710});
        end
        ntests++;
        if (o_tasma !== 1'b0) begin
            nfail++;
            $display("FAIL tasma_clean got=%b exp=0", o_tasma);
        end
    endtask

    task automatic test_full_wrap();
        ent_t h;
        for (int i = 0; i < 4; i++) push(32'h1000 + 32'(i * 16), 1'(i % 2), 32'h2000 + 32'(i * 8));
        ntests++;
        if ({o_dolu, o_bos, o_tasma} !== 3'b100) begin
            nfail++;
            $display("FAIL full_flag got=%b exp=100", {o_dolu, o_bos, o_tasma});
        end
        push(32'hDEAD0, 1, 32'hBEEF0);
        ntests++;
        if ({o_dolu, o_tasma} !== 2'b11) begin
            nfail++;
            $display("FAIL overflow got=%b exp=11", {o_dolu, o_tasma});
        end
        for (int k = 0; k < 7; k++) begin
            h = mq[0];
            step(1, 32'h3000 + 32'(k * 4), 1'(k % 2), 32'h4000 + 32'(k), 1, $urandom, h.pc, h.tk,
                 h.tk ? h.tgt : $urandom);
            ntests++;
            if ({o_upd, o_yan, o_dolu, o_eadr, o_dogru} !== {3'b101, h.pc, h.tk ? h.tgt : h.pc + 32'd4}) begin
                nfail++;
                $display("FAIL wrap_%0d got=%h exp=%h", k, {o_upd, o_yan, o_dolu, o_eadr, o_dogru},
                         {3'b101, h.pc, h.tk ? h.tgt : h.pc + 32'd4});
            end
        end
        while (mq.size() > 0) begin
            h = mq[0];
            resolve(h.pc, h.tk, h.tk ? h.tgt : 32'h0);
            ntests++;
            if (o_yan !== 1'b0) begin
                nfail++;
                $display("FAIL drain got=%b exp=0", o_yan);
            end
        end
        ntests++;
        if (o_bos !== 1'b1) begin
            nfail++;
            $display("FAIL drained_empty got=%b exp=1", o_bos);
        end
    endtask

    task automatic test_random();
        ent_t h;
        logic spv, scv, sct;
        logic [31:0] sca, sch;
        for (int n = 0; n < 400; n++) begin
            spv = 1'($urandom_range(0, 1));
            scv = 1'($urandom_range(0, 2) == 0);
            if (scv && mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                h = mq[0];
                sca = h.pc; sct = h.tk; sch = h.tk ? h.tgt : $urandom;
            end else begin
                sca = {$urandom_range(0, 63), 2'b00};
                sct = 1'($urandom_range(0, 1));
                sch = {$urandom_range(0, 63), 2'b00};
            end
            step(spv, {$urandom_range(0, 63), 2'b00}, 1'($urandom_range(0, 1)),
                 {$urandom_range(0, 63), 2'b00}, scv, $urandom, sca, sct, sch);
            ntests++;
            if ({o_upd, o_yan, o_tem, o_tasma, o_bos, o_dolu, o_atl, o_buy, o_eadr, o_hdf, o_dogru} !==
                {e_upd, e_yan, e_yan, e_tasma, mq.size() == 0, mq.size() == 4, e_atl, e_buy, e_adr, e_hdf, e_dogru}) begin
                nfail++;
                $display("FAIL random_%0d got=%h exp=%h", n,
                         {o_upd, o_yan, o_tem, o_tasma, o_bos, o_dolu, o_atl, o_buy, o_eadr, o_hdf, o_dogru},
                         {e_upd, e_yan, e_yan, e_tasma, mq.size() == 0, mq.size() == 4, e_atl, e_buy, e_adr, e_hdf, e_dogru});
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) push(32'h5000 + 32'(i * 4), 1, 32'h6000);
        resolve(32'h9999, 1, 32'h7777);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        ntests++;
        if ({o_bos, o_dolu, o_tasma, o_upd, o_yan, o_tem, o_dogru, o_eadr} !== {6'b100000, 64'h0}) begin
            nfail++;
            $display("FAIL reset_mid got=%h exp=%h", {o_bos, o_dolu, o_tasma, o_upd, o_yan, o_tem, o_dogru, o_eadr},
                     {6'b100000, 64'h0});
        end
        pv = 0; cv = 0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        resolve(32'h800, 1, 32'h900);
        ntests++;
        if ({o_upd, o_yan, o_tem, o_tasma, o_dogru} !== {4'b1111, 32'h900}) begin
            nfail++;
            $display("FAIL empty_pop_taken got=%h exp=%h", {o_upd, o_yan, o_tem, o_tasma, o_dogru}, {4'b1111, 32'h900});
        end
        resolve(32'h820, 0, 32'h0);
        ntests++;
        if ({o_upd, o_yan, o_tasma, o_dogru} !== {3'b101, 32'h824}) begin
            nfail++;
            $display("FAIL empty_pop_nt got=%h exp=%h", {o_upd, o_yan, o_tasma, o_dogru}, {3'b101, 32'h824});
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_correct_taken();
        test_direction_mispredict();
        test_target_mispredict();
        test_full_wrap();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/dallanma_cozucu.md
Name: dallanma_cozucu

Overview:
- Resolution-side counterpart of the branch predictor.
- Records every prediction issued at fetch in an in-order queue.
- At execute, compares the oldest recorded prediction against the actual branch outcome.
- Drives the predictor's training interface (old instruction, old PC, taken, target, mispredict) and the pipeline flush/redirect.

Parameters:
- DERINLIK, 4, in-flight prediction queue depth (power of two, 2..16)
- ADRES_GENISLIGI, 32, PC/target width

Ports:
- i_saat  in  1  clock, rising edge
- i_reset_n  in  1  asynchronous active-low reset
- i_ongoru_gecerli  in  1  fetch issued a prediction this cycle (push)
- i_ongoru_adresi  in  32  PC of predicted branch
- i_ongoru_atladi  in  1  predicted taken
- i_ongoru_hedef  in  32  predicted target
- o_dolu  out  1  queue full; fetch must stall branch issue
- o_bos  out  1  queue empty
- i_coz_gecerli  in  1  execute resolved a conditional branch (pop)
- i_coz_buyruk  in  32  resolved instruction word
- i_coz_adresi  in  32  PC of resolved branch
- i_coz_atladi  in  1  actual taken
- i_coz_hedef  in  32  actual taken target
- o_guncelle_gecerli  out  1  training strobe to predictor
- o_eski_buyruk  out  32  instruction for training
- o_eski_buyruk_adresi  out  32  PC for training
- o_buyruk_atladi  out  1  actual outcome
- o_atlanan_adres  out  32  actual target
- o_ongoru_yanlis  out  1  mispredict flag
- o_boru_temizle  out  1  flush younger instructions
- o_dogru_adres  out  32  redirect PC
- o_tasma  out  1  sticky error: push while full or pop while empty

Behaviour:
- Reset (async, i_reset_n=0): queue empty (o_bos=1, o_dolu=0), read/write pointers and count 0, all outputs 0, o_tasma=0. Deassertion is sampled at the next rising edge.
- Queue:
  - Circular buffer with DERINLIK entries {pc, taken, target}.
  - Pointers wrap modulo DERINLIK; count is $clog2(DERINLIK)+1 bits.
  - o_dolu = (count==DERINLIK); o_bos = (count==0), both combinational from count.
- Push: i_ongoru_gecerli & !o_dolu writes the tail entry; count+1.
- Pop: i_coz_gecerli reads the head entry combinationally and compares it in the same cycle.
- Mispredict condition (m):
  - predicted taken != i_coz_atladi, OR
  - both taken and predicted target != i_coz_hedef, OR
  - head pc != i_coz_adresi (desync).
- Outputs: registered, 1-cycle latency. At edge after pop cycle N, during N+1:
  - o_guncelle_gecerli=1
  - o_eski_buyruk=i_coz_buyruk, o_eski_buyruk_adresi=i_coz_adresi
  - o_buyruk_atladi=i_coz_atladi, o_atlanan_adres=i_coz_hedef
  - o_ongoru_yanlis=m, o_boru_temizle=m
  - o_dogru_adres = i_coz_atladi ? i_coz_hedef : i_coz_adresi+4 (mod 2^32)
- Strobes: o_guncelle_gecerli, o_ongoru_yanlis and o_boru_temizle are single-cycle pulses. Data outputs hold their last value.
- Mispredict flush: on m=1, at the same edge all remaining entries are discarded (pointers reset, count=0). Any push in that cycle is dropped, since it belongs to the wrong path.
- Simultaneous push+pop without mispredict: both performed, count unchanged. Allowed even when full (the pop frees a slot first) — push accepted when o_dolu & pop & !m.
- Push while full without pop: entry dropped, o_tasma set.
- Pop while empty:
  - Treated as predicted not-taken, target 0, so m = i_coz_atladi.
  - Training and redirect are still issued.
  - o_tasma set.
- o_tasma clears only on reset.

Optional Feature:
- Macro: PERF_SAYAC_EN.
- When defined, adds ports:
  - o_cozulen_sayisi (32, out): count of pops.
  - o_yanlis_sayisi (32, out): count of mispredicts.
  - Both counters saturate at 32'hFFFF_FFFF, reset to 0, and update on the same edge as the outputs.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Correct taken: push {pc=0x100, taken=1, tgt=0x180}; resolve {0x100, taken=1, 0x180} -> next cycle guncelle=1, yanlis=0, temizle=0, dogru_adres=0x180, o_bos=1.
- Direction mispredict: push {0x200, 0, 0}, push {0x204, 1, 0x300}; resolve {0x200, taken=1, 0x240} -> yanlis=1, temizle=1, dogru_adres=0x240, queue empty (second entry discarded).
- Not-taken redirect/target mispredict: push {0x400, 1, 0x500}; resolve {0x400, 0, x} -> yanlis=1, dogru_adres=0x404. Separately push {0x600, 1, 0x700}, resolve taken to 0x710 -> yanlis=1, dogru_adres=0x710.
- Full/wrap: DERINLIK=4, push 4 -> o_dolu=1. 5th push alone -> dropped, o_tasma=1. Push+pop same cycle at full -> count stays 4. Then 6 more push/pop pairs -> FIFO order preserved across wrap.
- Reset mid-operation: 3 entries queued, drive i_reset_n=0 asynchronously between edges -> o_bos=1, all outputs 0, o_tasma=0 immediately. First resolve after release -> empty-pop handling.
- PERF_SAYAC_EN defined: 10 resolves, 3 mispredicts -> o_cozulen_sayisi=10, o_yanlis_sayisi=3. Preload near max via force -> counters saturate at 0xFFFFFFFF.
